// File: rtl/oam_dma_bus_arbiter_pkg.sv
// Shared constants, FSM encoding and source-page helper for the OAM DMA bus arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package oam_dma_bus_arbiter_pkg;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] HRAM_BASE    = 16'hFF00;
    localparam int          OAM_LENGTH   = 160;
    localparam int          START_DELAY  = 1;

    localparam logic [7:0]  LAST_IDX     = 8'(OAM_LENGTH - 1);
    localparam logic [3:0]  LAST_DLY     = 4'(START_DELAY - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_XFER  = 2'd2,
        ST_DRAIN = 2'd3
    } dma_state_t;

    // Pages E0..FF mirror C0..DF, so the DMA reads the mirrored page instead.
    function automatic logic [7:0] eff_src(input logic [7:0] src);
        return (src >= 8'hE0) ? (src - 8'h20) : src;
    endfunction

endpackage

// File: rtl/oam_dma_bus_arbiter_sequencer.sv
// OAM DMA sequencer: start delay, 160 source reads, OAM writes trailing one tick behind.
// Latency: first read START_DELAY ticks after start; each OAM write lands one tick after its read.
// Backpressure: none; advances only on i_Enable ticks, a new start restarts and drops the pending byte.
module oam_dma_bus_arbiter_sequencer
    import oam_dma_bus_arbiter_pkg::*;
(
    input  logic        i_Clk,
    input  logic        i_nRst,
    input  logic        i_Enable,
    input  logic        i_Start,
    input  logic [7:0]  i_Mem_Bus,
    output dma_state_t  o_State,
    output logic [7:0]  o_Idx,
    output logic [7:0]  o_OAM_Address,
    output logic [7:0]  o_OAM_Data,
    output logic        o_OAM_Write
);

    dma_state_t  state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [3:0]  dly_q, dly_d;
    logic [7:0]  latch_q, latch_d;
    logic        pend_q, pend_d;

    // State register plus the index, delay counter and one-byte write pipeline.
    always_ff @(posedge i_Clk or negedge i_nRst) begin
        if (!i_nRst) begin
            state_q <= ST_IDLE;
            idx_q   <= 8'h00;
            dly_q   <= 4'h0;
            latch_q <= 8'h00;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dly_q   <= dly_d;
            latch_q <= latch_d;
            pend_q  <= pend_d;
        end
    end

    // Next-state logic; a start always wins so a mid-transfer write restarts cleanly.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dly_d   = dly_q;
        latch_d = latch_q;
        pend_d  = pend_q;
        if (i_Enable) begin
            if (i_Start) begin
                state_d = ST_DELAY;
                idx_d   = 8'h00;
                dly_d   = 4'h0;
                pend_d  = 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_d = ST_IDLE;
                    end
                    ST_DELAY: begin
                        if (dly_q == LAST_DLY) begin
                            state_d = ST_XFER;
                        end else begin
                            dly_d = dly_q + 4'h1;
                        end
                    end
                    ST_XFER: begin
                        latch_d = i_Mem_Bus;
                        pend_d  = 1'b1;
                        idx_d   = idx_q + 8'h01;
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        state_d = ST_IDLE;
                        pend_d  = 1'b0;
                    end
                    default: begin
                        state_d = ST_IDLE;
                        pend_d  = 1'b0;
                    end
                endcase
            end
        end
    end

    // The pending byte belongs to the previous index; suppressed on a restart tick.
    always_comb begin
        o_State       = state_q;
        o_Idx         = idx_q;
        o_OAM_Write   = pend_q & i_Enable & ~i_Start;
        o_OAM_Address = pend_q ? (idx_q - 8'h01) : 8'h00;
        o_OAM_Data    = pend_q ? latch_q : 8'h00;
    end

endmodule

// File: rtl/oam_dma_bus_arbiter.sv
// CPU bus owner: routes CPU cycles to main bus or high page, fences the CPU during OAM DMA.
// Latency: routing is combinational; DMA takes START_DELAY + OAM_LENGTH + 1 ticks.
// Backpressure: none; fenced low-page CPU reads return FF and writes are dropped.
module oam_dma_bus_arbiter
    import oam_dma_bus_arbiter_pkg::*;
(
    input  logic        i_Clk,
    input  logic        i_nRst,
    input  logic        i_Enable,
    input  logic [15:0] i_CPU_Address,
    input  logic [7:0]  i_CPU_Bus,
    input  logic        i_CPU_Bus_Out,
    input  logic        i_CPU_Bus_In,
    output logic [7:0]  o_CPU_Bus,
    output logic [15:0] o_Mem_Address,
    output logic [7:0]  o_Mem_Bus,
    output logic        o_Mem_Write,
    output logic        o_Mem_Read,
    input  logic [7:0]  i_Mem_Bus,
    output logic [7:0]  o_HP_Address,
    output logic [7:0]  o_HP_Bus,
    output logic        o_HP_Write,
    output logic        o_HP_Read,
    input  logic [7:0]  i_HP_Bus,
    output logic [7:0]  o_OAM_Address,
    output logic [7:0]  o_OAM_Data,
    output logic        o_OAM_Write,
    output logic        o_DMA_Active
);

    logic [7:0]  src_q;
    dma_state_t  state;
    logic [7:0]  idx;
    logic        is_reg;
    logic        is_low;
    logic        is_hp;
    logic        cpu_act;
    logic        reg_wr;
    logic        fenced;

    assign is_reg  = (i_CPU_Address == DMA_REG_ADDR);
    assign is_low  = (i_CPU_Address < HRAM_BASE);
    assign is_hp   = !is_low && !is_reg;
    assign cpu_act = i_CPU_Bus_Out | i_CPU_Bus_In;
    assign reg_wr  = i_Enable & i_CPU_Bus_Out & is_reg;
    assign fenced  = (state != ST_IDLE);

    // DMA source page register, loaded by the CPU write that starts a transfer.
    always_ff @(posedge i_Clk or negedge i_nRst) begin
        if (!i_nRst) begin
            src_q <= 8'h00;
        end else if (reg_wr) begin
            src_q <= i_CPU_Bus;
        end
    end

    oam_dma_bus_arbiter_sequencer u_seq (
        .i_Clk         (i_Clk),
        .i_nRst        (i_nRst),
        .i_Enable      (i_Enable),
        .i_Start       (reg_wr),
        .i_Mem_Bus     (i_Mem_Bus),
        .o_State       (state),
        .o_Idx         (idx),
        .o_OAM_Address (o_OAM_Address),
        .o_OAM_Data    (o_OAM_Data),
        .o_OAM_Write   (o_OAM_Write)
    );

    assign o_DMA_Active = fenced;

    // Main bus: DMA reads while fenced, otherwise low-page CPU cycles pass through.
    always_comb begin
        o_Mem_Address = 16'h0000;
        o_Mem_Bus     = 8'h00;
        o_Mem_Write   = 1'b0;
        o_Mem_Read    = 1'b0;
        if (fenced) begin
            if (state == ST_XFER) begin
                o_Mem_Address = {eff_src(src_q), idx};
                o_Mem_Read    = i_Enable;
            end
        end else if (is_low && cpu_act) begin
            o_Mem_Address = i_CPU_Address;
            o_Mem_Bus     = i_CPU_Bus_Out ? i_CPU_Bus : 8'h00;
            o_Mem_Write   = i_Enable & i_CPU_Bus_Out;
            o_Mem_Read    = i_Enable & i_CPU_Bus_In;
        end
    end

    // High page is never fenced, so code can keep running from HRAM during DMA.
    always_comb begin
        o_HP_Address = 8'h00;
        o_HP_Bus     = 8'h00;
        o_HP_Write   = 1'b0;
        o_HP_Read    = 1'b0;
        if (is_hp && cpu_act) begin
            o_HP_Address = i_CPU_Address[7:0];
            o_HP_Bus     = i_CPU_Bus_Out ? i_CPU_Bus : 8'h00;
            o_HP_Write   = i_Enable & i_CPU_Bus_Out;
            o_HP_Read    = i_Enable & i_CPU_Bus_In;
        end
    end

    // CPU read data: register, high page, open-bus FF when fenced, else main bus.
    always_comb begin
        o_CPU_Bus = 8'h00;
        if (i_CPU_Bus_In) begin
            if (is_reg) begin
                o_CPU_Bus = src_q;
            end else if (is_hp) begin
                o_CPU_Bus = i_HP_Bus;
            end else if (fenced) begin
                o_CPU_Bus = 8'hFF;
            end else begin
                o_CPU_Bus = i_Mem_Bus;
            end
        end
    end

endmodule

// File: tb/tb_oam_dma_bus_arbiter.sv
module tb_oam_dma_bus_arbiter;

    logic        clk = 1'b0;
    logic        i_nRst;
    logic        i_Enable;
    logic [15:0] i_CPU_Address;
    logic [7:0]  i_CPU_Bus;
    logic        i_CPU_Bus_Out;
    logic        i_CPU_Bus_In;
    logic [7:0]  o_CPU_Bus;
    logic [15:0] o_Mem_Address;
    logic [7:0]  o_Mem_Bus;
    logic        o_Mem_Write;
    logic        o_Mem_Read;
    logic [7:0]  i_Mem_Bus;
    logic [7:0]  o_HP_Address;
    logic [7:0]  o_HP_Bus;
    logic        o_HP_Write;
    logic        o_HP_Read;
    logic [7:0]  i_HP_Bus;
    logic [7:0]  o_OAM_Address;
    logic [7:0]  o_OAM_Data;
    logic        o_OAM_Write;
    logic        o_DMA_Active;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } oam_t;

    oam_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    oam_dma_bus_arbiter dut (
        .i_Clk         (clk),
        .i_nRst        (i_nRst),
        .i_Enable      (i_Enable),
        .i_CPU_Address (i_CPU_Address),
        .i_CPU_Bus     (i_CPU_Bus),
        .i_CPU_Bus_Out (i_CPU_Bus_Out),
        .i_CPU_Bus_In  (i_CPU_Bus_In),
        .o_CPU_Bus     (o_CPU_Bus),
        .o_Mem_Address (o_Mem_Address),
        .o_Mem_Bus     (o_Mem_Bus),
        .o_Mem_Write   (o_Mem_Write),
        .o_Mem_Read    (o_Mem_Read),
        .i_Mem_Bus     (i_Mem_Bus),
        .o_HP_Address  (o_HP_Address),
        .o_HP_Bus      (o_HP_Bus),
        .o_HP_Write    (o_HP_Write),
        .o_HP_Read     (o_HP_Read),
        .i_HP_Bus      (i_HP_Bus),
        .o_OAM_Address (o_OAM_Address),
        .o_OAM_Data    (o_OAM_Data),
        .o_OAM_Write   (o_OAM_Write),
        .o_DMA_Active  (o_DMA_Active)
    );

    // Memory contents: page C1 gives i^5A, other pages give distinct patterns.
    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h9B;
    endfunction

    function automatic logic [7:0] src_page(input logic [7:0] s);
        return (s >= 8'hE0) ? (s - 8'h20) : s;
    endfunction

    always_comb i_Mem_Bus = mem_f(o_Mem_Address);

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic push_xfer(input logic [7:0] src, input int n);
        oam_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = 8'(i);
            e.data = mem_f({src_page(src), 8'(i)});
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cpu();
        i_CPU_Address = 16'h0000;
        i_CPU_Bus     = 8'h00;
        i_CPU_Bus_Out = 1'b0;
        i_CPU_Bus_In  = 1'b0;
    endtask

    task automatic reg_write(input logic [7:0] v);
        i_CPU_Address = 16'hFF46;
        i_CPU_Bus     = v;
        i_CPU_Bus_Out = 1'b1;
        tick();
        idle_cpu();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (o_DMA_Active === 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (o_DMA_Active !== 1'b0) begin
            errors++;
            $display("FAIL %s: DMA still active after %0d ticks, required idle", name, n);
        end
        tick();
    endtask

    // Leaves the caller at the negedge where the DMA reads index v.
    task automatic wait_idx(input logic [7:0] v, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(o_Mem_Read === 1'b1 && o_Mem_Address[7:0] === v) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(o_Mem_Read === 1'b1 && o_Mem_Address[7:0] === v)) begin
            errors++;
            $display("FAIL %s: read of idx %h never seen, last addr %h", name, v, o_Mem_Address);
        end
    endtask

    // Scoreboard monitor: every OAM write strobe must match the next expected byte.
    initial begin
        oam_t e;
        forever begin
            @(negedge clk);
            if (o_OAM_Write === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL oam_unexpected: got write addr %h data %h, required no write",
                             o_OAM_Address, o_OAM_Data);
                end else begin
                    e = exp_q.pop_front();
                    check("oam_addr", {8'h00, o_OAM_Address}, {8'h00, e.addr});
                    check("oam_data", {8'h00, o_OAM_Data}, {8'h00, e.data});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int          cnt;
        logic [15:0] held;

        i_nRst   = 1'b0;
        i_Enable = 1'b1;
        i_HP_Bus = 8'h3C;
        idle_cpu();

        // Reset state
        #3;
        check("rst_active",   {15'h0, o_DMA_Active}, 16'h0000);
        check("rst_oam_wr",   {15'h0, o_OAM_Write},  16'h0000);
        check("rst_oam_addr", {8'h00, o_OAM_Address}, 16'h0000);
        check("rst_mem_addr", o_Mem_Address,         16'h0000);
        check("rst_mem_rd",   {15'h0, o_Mem_Read},   16'h0000);
        check("rst_cpu_bus",  {8'h00, o_CPU_Bus},    16'h0000);
        tick();
        i_nRst = 1'b1;
        tick();
        i_CPU_Address = 16'hFF46;
        i_CPU_Bus_In  = 1'b1;
        @(negedge clk);
        check("rst_src_reg", {8'h00, o_CPU_Bus}, 16'h0000);
        tick();
        idle_cpu();

        // 1: full copy from C1, active window length
        push_xfer(8'hC1, 160);
        reg_write(8'hC1);
        cnt = 0;
        while (cnt < 400) begin
            @(negedge clk);
            if (o_DMA_Active !== 1'b1) break;
            cnt++;
            if (cnt == 1) check("t1_delay_no_read", {15'h0, o_Mem_Read}, 16'h0000);
            if (cnt == 2) check("t1_first_addr", o_Mem_Address, 16'hC100);
        end
        check("t1_active_ticks", 16'(cnt), 16'd162);
        tick();
        check("t1_sb_empty", 16'(exp_q.size()), 16'd0);

        // 2/3: fencing of low page, HP port open during DMA
        push_xfer(8'hC1, 160);
        reg_write(8'hC1);
        tick();
        tick();
        i_CPU_Address = 16'h0000;
        i_CPU_Bus_In  = 1'b1;
        @(negedge clk);
        check("t2_fenced_read", {8'h00, o_CPU_Bus}, 16'h00FF);
        check("t2_bus_is_dma",  {8'h00, o_Mem_Address[15:8]}, 16'h00C1);
        tick();
        i_CPU_Bus_In  = 1'b0;
        i_CPU_Address = 16'hC000;
        i_CPU_Bus     = 8'h77;
        i_CPU_Bus_Out = 1'b1;
        @(negedge clk);
        check("t2_fenced_wr", {15'h0, o_Mem_Write}, 16'h0000);
        check("t2_wr_bus",    {8'h00, o_Mem_Bus},   16'h0000);
        tick();
        i_CPU_Bus_Out = 1'b0;
        i_CPU_Address = 16'hFF90;
        i_CPU_Bus_In  = 1'b1;
        @(negedge clk);
        check("t3_hp_read",  {15'h0, o_HP_Read},   16'h0001);
        check("t3_hp_addr",  {8'h00, o_HP_Address}, 16'h0090);
        check("t3_hp_data",  {8'h00, o_CPU_Bus},   16'h003C);
        check("t3_bus_dma",  {8'h00, o_Mem_Address[15:8]}, 16'h00C1);
        tick();
        i_CPU_Bus_In  = 1'b0;
        i_CPU_Bus     = 8'h99;
        i_CPU_Bus_Out = 1'b1;
        @(negedge clk);
        check("t3_hp_write", {15'h0, o_HP_Write}, 16'h0001);
        check("t3_hp_wdata", {8'h00, o_HP_Bus},   16'h0099);
        check("t3_no_mem_wr", {15'h0, o_Mem_Write}, 16'h0000);
        tick();
        idle_cpu();
        wait_idle("t2_idle");
        i_CPU_Address = 16'h0000;
        i_CPU_Bus_In  = 1'b1;
        @(negedge clk);
        check("t2_pass_rd",   {15'h0, o_Mem_Read}, 16'h0001);
        check("t2_pass_addr", o_Mem_Address,       16'h0000);
        check("t2_pass_data", {8'h00, o_CPU_Bus},  16'h009B);
        tick();
        i_CPU_Bus_In  = 1'b0;
        i_CPU_Address = 16'hC000;
        i_CPU_Bus     = 8'h77;
        i_CPU_Bus_Out = 1'b1;
        @(negedge clk);
        check("t2_pass_wr",    {15'h0, o_Mem_Write}, 16'h0001);
        check("t2_pass_waddr", o_Mem_Address,        16'hC000);
        check("t2_pass_wdata", {8'h00, o_Mem_Bus},   16'h0077);
        tick();
        idle_cpu();
        check("t2_sb_empty", 16'(exp_q.size()), 16'd0);

        // 4: restart from D0 while the C1 byte 50 is pending
        push_xfer(8'hC1, 50);
        reg_write(8'hC1);
        wait_idx(8'd50, "t4_reach_50");
        tick();
        push_xfer(8'hD0, 160);
        i_CPU_Address = 16'hFF46;
        i_CPU_Bus     = 8'hD0;
        i_CPU_Bus_Out = 1'b1;
        @(negedge clk);
        check("t4_drop_pending", {15'h0, o_OAM_Write}, 16'h0000);
        tick();
        idle_cpu();
        @(negedge clk);
        check("t4_delay_no_read", {15'h0, o_Mem_Read}, 16'h0000);
        tick();
        @(negedge clk);
        check("t4_restart_addr", o_Mem_Address, 16'hD000);
        tick();
        wait_idle("t4_idle");
        check("t4_sb_empty", 16'(exp_q.size()), 16'd0);

        // 5: mirrored source page FE -> DE
        push_xfer(8'hFE, 160);
        reg_write(8'hFE);
        i_CPU_Address = 16'hFF46;
        i_CPU_Bus_In  = 1'b1;
        @(negedge clk);
        check("t5_reg_read", {8'h00, o_CPU_Bus}, 16'h00FE);
        check("t5_reg_not_hp", {15'h0, o_HP_Read}, 16'h0000);
        tick();
        idle_cpu();
        @(negedge clk);
        check("t5_src_addr", o_Mem_Address, 16'hDE00);
        tick();
        wait_idle("t5_idle");
        check("t5_sb_empty", 16'(exp_q.size()), 16'd0);

        // 6: enable stall, then reset mid-transfer
        push_xfer(8'hC1, 80);
        reg_write(8'hC1);
        wait_idx(8'd20, "t6_reach_20");
        tick();
        i_Enable = 1'b0;
        @(negedge clk);
        held = o_Mem_Address;
        check("t6_stall_addr", held, 16'hC115);
        check("t6_stall_no_rd", {15'h0, o_Mem_Read}, 16'h0000);
        repeat (10) @(posedge clk);
        #1;
        check("t6_no_advance", o_Mem_Address, 16'hC115);
        i_Enable = 1'b1;
        wait_idx(8'd80, "t6_reach_80");
        #2;
        i_nRst = 1'b0;
        #1;
        check("t6_rst_active",   {15'h0, o_DMA_Active}, 16'h0000);
        check("t6_rst_oam_wr",   {15'h0, o_OAM_Write},  16'h0000);
        check("t6_rst_oam_addr", {8'h00, o_OAM_Address}, 16'h0000);
        check("t6_rst_oam_data", {8'h00, o_OAM_Data},   16'h0000);
        check("t6_rst_mem_addr", o_Mem_Address,         16'h0000);
        check("t6_rst_mem_rd",   {15'h0, o_Mem_Read},   16'h0000);
        tick();
        i_nRst = 1'b1;
        repeat (20) tick();
        check("t6_stays_idle", {15'h0, o_DMA_Active}, 16'h0000);
        check("t6_sb_empty", 16'(exp_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
